// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width, per-cycle slice width and the
// sequencing states used by the multi-cycle arithmetic blocks.
package alu_pkg;

    localparam int ALU_WIDTH = 32;
    localparam int SLICE_W   = 4;
    localparam int NIBBLES   = ALU_WIDTH / SLICE_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sub4.sv
// 4-bit ripple-borrow subtractor: {bout, d} = a - b - bin.
// Ports:
//   a, b  : 4-bit minuend / subtrahend
//   bin   : borrow-in
//   d     : 4-bit difference
//   bout  : borrow-out (1 when a < b + bin)
module sub4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       bin,
    output logic [3:0] d,
    output logic       bout
);

    logic [4:0] br;

    // Four full-subtractor cells chained through br.
    always_comb begin
        br    = '0;
        d     = '0;
        br[0] = bin;
        for (int unsigned i = 0; i < 4; i++) begin
            d[i]    = a[i] ^ b[i] ^ br[i];
            br[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br[i]);
        end
        bout = br[4];
    end

endmodule

// File: rtl/serial_sub32.sv
// Multi-cycle subtractor: computes a - b - bin one 4-bit nibble per cycle,
// least-significant nibble first, and reports unsigned borrow, zero, signed
// overflow and signed less-than flags under a start/busy/done handshake.
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   start            : request, accepted in IDLE or DONE
//   a, b, bin        : operands and borrow-in, latched on accepted start
//   busy             : nibbles being processed
//   done             : one-cycle pulse, result valid
//   diff             : a - b - bin modulo 2^WIDTH
//   bout, zero, ovf, lt : borrow, diff==0, signed overflow, signed a<b
module serial_sub32
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int SLICE = SLICE_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero,
    output logic             ovf,
    output logic             lt
);

    localparam int NIB = WIDTH / SLICE;
    localparam int KW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NIB - 1);

    state_t            state, state_nxt;
    logic [KW-1:0]     k;
    logic [WIDTH-1:0]  a_r, b_r;
    logic              brw;
    logic              accept;
    logic              last;

    logic [SLICE-1:0]  s_a, s_b, s_d;
    logic              s_bout;
    logic [WIDTH-1:0]  diff_nxt;
    logic              ovf_nxt;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last      = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (k == K_LAST) begin
                    last      = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- Datapath ----------------
    assign s_a = a_r[int'(k)*SLICE +: SLICE];
    assign s_b = b_r[int'(k)*SLICE +: SLICE];

    sub4 u_sub4 (
        .a    (s_a),
        .b    (s_b),
        .bin  (brw),
        .d    (s_d),
        .bout (s_bout)
    );

    // Flags are derived from the diff value including the nibble written
    // this cycle, so they register together with the last nibble.
    always_comb begin
        diff_nxt                         = diff;
        diff_nxt[int'(k)*SLICE +: SLICE] = s_d;
        ovf_nxt = (a_r[WIDTH-1] != b_r[WIDTH-1]) &&
                  (diff_nxt[WIDTH-1] != a_r[WIDTH-1]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            k    <= '0;
            a_r  <= '0;
            b_r  <= '0;
            brw  <= 1'b0;
            diff <= '0;
            bout <= 1'b0;
            zero <= 1'b0;
            ovf  <= 1'b0;
            lt   <= 1'b0;
        end else if (accept) begin
            k    <= '0;
            a_r  <= a;
            b_r  <= b;
            brw  <= bin;
            diff <= '0;
            bout <= 1'b0;
            zero <= 1'b0;
            ovf  <= 1'b0;
            lt   <= 1'b0;
        end else if (state == RUN) begin
            diff <= diff_nxt;
            brw  <= s_bout;
            k    <= k + 1'b1;
            if (last) begin
                bout <= s_bout;
                zero <= (diff_nxt == '0);
                ovf  <= ovf_nxt;
                lt   <= diff_nxt[WIDTH-1] ^ ovf_nxt;
            end
        end
    end

endmodule

// File: tb/tb_serial_sub32.sv
module tb_serial_sub32;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] a, b;
    logic        bin;
    logic        busy, done;
    logic [31:0] diff;
    logic        bout, zero, ovf, lt;

    serial_sub32 #(.WIDTH(32), .SLICE(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .zero  (zero),
        .ovf   (ovf),
        .lt    (lt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] diff;
        logic        bout;
        logic        zero;
        logic        ovf;
        logic        lt;
    } exp_t;

    exp_t q[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference: plain wide arithmetic on the operands.
    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic bi, input int due);
        exp_t   e;
        longint r;
        logic [32:0] u;
        u = {1'b0, x} - {1'b0, y} - {32'd0, bi};
        r = longint'($signed(x)) - longint'($signed(y)) - longint'(bi);
        e.due  = due;
        e.diff = u[31:0];
        e.bout = u[32];
        e.zero = (u[31:0] == 32'd0);
        e.ovf  = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        e.lt   = (r < 0);
        return e;
    endfunction

    // Monitor: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("done_cycle", 64'(cyc), 64'(e.due));
                chk("busy_at_done", {63'd0, busy}, 64'd0);
                chk("diff", {32'd0, diff}, {32'd0, e.diff});
                chk("bout", {63'd0, bout}, {63'd0, e.bout});
                chk("zero", {63'd0, zero}, {63'd0, e.zero});
                chk("ovf",  {63'd0, ovf},  {63'd0, e.ovf});
                chk("lt",   {63'd0, lt},   {63'd0, e.lt});
            end
        end
    end

    // Drive one start; accepted at the next posedge (E0), done visible after E0+8.
    task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic bi);
        @(negedge clk);
        a = x; b = y; bin = bi; start = 1'b1;
        @(posedge clk);
        #1;
        q.push_back(model(x, y, bi, cyc + 8));
        chk("busy_after_start", {63'd0, busy}, 64'd1);
        start = 1'b0;
        a = $urandom; b = $urandom; bin = 1'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || busy === 1'b1) && n < 40) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        if (n >= 40) begin
            chk("drain_timeout", 64'd1, 64'd0);
            q.delete();
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
        chk({tag, "_done"}, {63'd0, done}, 64'd0);
        chk({tag, "_diff"}, {32'd0, diff}, 64'd0);
        chk({tag, "_flags"}, {60'd0, bout, zero, ovf, lt}, 64'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero_outputs("reset");
        rst = 1'b0;

        // Directed cases.
        issue(32'd5, 32'd3, 1'b0);            drain();
        issue(32'd0, 32'd1, 1'b0);            drain();
        issue(32'h8000_0000, 32'd1, 1'b0);    drain();
        issue(32'h1234_ABCD, 32'h1234_ABCD, 1'b0); drain();
        issue(32'd7, 32'd7, 1'b1);            drain();
        issue(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0); drain();
        issue(32'h8000_0000, 32'd0, 1'b1);    drain();

        // Start held during RUN with other operands is ignored.
        issue(32'h0000_1000, 32'h0000_0001, 1'b0);
        @(negedge clk);
        a = 32'hDEAD_BEEF; b = 32'h1; bin = 1'b1; start = 1'b1;
        repeat (5) @(negedge clk);
        start = 1'b0;
        drain();

        // Start in the DONE cycle: second done 9 cycles after the first.
        issue(32'd100, 32'd58, 1'b0);
        repeat (8) @(posedge clk);
        issue(32'h0000_0010, 32'h0000_0020, 1'b1);
        drain();

        // Reset during the 4th RUN cycle aborts without a done.
        issue(32'h0F0F_0F0F, 32'h0101_0101, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1; start = 1'b1;
        @(posedge clk);
        #1;
        q.delete();
        rst = 1'b0; start = 1'b0;
        chk_zero_outputs("abort");
        repeat (12) @(posedge clk);
        issue(32'd9, 32'd4, 1'b0);
        drain();

        // Randomised operations, sometimes back-to-back.
        for (int i = 0; i < 40; i++) begin
            logic [31:0] x, y;
            x = $urandom;
            y = (($urandom_range(0, 4)) == 0) ? x : 32'($urandom);
            issue(x, y, 1'($urandom));
            if ($urandom_range(0, 2) == 0) begin
                repeat (8) @(posedge clk);
            end else begin
                drain();
                repeat ($urandom_range(0, 3)) @(posedge clk);
            end
        end
        drain();

        if (q.size() != 0) chk("pending_results", 64'(q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/serial_sub32.md
# serial_sub32

Multi-cycle 32-bit subtractor for the ALU datapath, built around a 4-bit ripple-borrow slice that is reused over eight cycles, least-significant nibble first. It pairs with the ripple-carry adder slices: they add, this block subtracts and compares. It accepts operands on a start pulse and returns the difference plus unsigned, signed and zero flags under a start/busy/done handshake. The ALU sequencer uses it for SUB, SLT and SLTU.

## Interface
- WIDTH, 32: operand width. Must be a multiple of SLICE.
- SLICE, 4: bits processed per cycle.
- clk  in  1  rising-edge clock (single clock domain).
- rst  in  1  synchronous, active-high reset.
- start  in  1  request. Sampled only when not busy.
- a  in  WIDTH  minuend, latched on accepted start.
- b  in  WIDTH  subtrahend, latched on accepted start.
- bin  in  1  borrow-in, latched on accepted start.
- busy  out  1  high while nibbles are being processed.
- done  out  1  one-cycle pulse when the result is valid.
- diff  out  WIDTH  a - b - bin, modulo 2^WIDTH.
- bout  out  1  final borrow. 1 means a < b + bin, unsigned.
- zero  out  1  diff == 0.
- ovf  out  1  signed overflow.
- lt  out  1  signed a < b, defined as diff[MSB] ^ ovf.

## Operation
- FSM states:
  - IDLE: busy=0.
  - RUN: busy=1, nibble counter k runs 0..WIDTH/SLICE-1.
  - DONE: done=1 for exactly one cycle, then returns to IDLE.
- Accepted start (state IDLE or DONE with start=1):
  - latch a, b and bin.
  - clear the diff register.
  - set k=0 and enter RUN.
- RUN, each cycle:
  - slice computes {borrow, d} = a[k] - b[k] - borrow_reg, using 4-bit nibbles.
  - d is written to diff[k*SLICE +: SLICE].
  - borrow_reg is updated with the slice borrow.
  - k increments.
  - when the last nibble is processed, enter DONE.
- Flags are registered together with the last nibble and are valid whenever done=1:
  - bout = final borrow_reg.
  - zero = (diff == 0).
  - ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]).
  - lt = diff[MSB] ^ ovf.
- Outputs diff, bout, zero, ovf and lt hold their values after done until the next accepted start. They are not valid while busy=1.
- start while busy=1 is ignored, with no queueing. Operand changes during RUN have no effect.
- start in the DONE cycle is accepted; this gives back-to-back operations.

## Timing
- Reset (rst=1 at an edge): state IDLE, k=0, borrow_reg=0, and all outputs 0 (busy, done, diff, bout, zero, ovf, lt).
- rst overrides everything, including start in the same cycle and an operation in progress. No done pulse is produced for an aborted operation.
- Latency: start accepted at edge E0, busy=1 after E0, nibbles processed at E1..E8, done=1 and busy=0 after E8. That is 8 cycles from start to done for WIDTH=32.
- Throughput: one operation per 9 cycles. A start in the DONE cycle gives the same 8-cycle latency.
- Simultaneous start and DONE: done pulses in that cycle and busy rises at the next edge.

## Structure
- Shared package alu_pkg holds:
  - ALU_WIDTH = 32 and SLICE_W = 4.
  - NIBBLES = ALU_WIDTH/SLICE_W.
  - the state enum (IDLE, RUN, DONE).
- Sub-module sub4: combinational 4-bit ripple-borrow subtractor.
  - ports: a[3:0], b[3:0], bin → d[3:0], bout.
  - built from four full-subtractor bit cells.
  - instantiated once, with nibble selection done by the mux on k.
- Counter width is $clog2(NIBBLES). The nibble mux and the diff write use indexed part-selects.

## Test plan
- a=5, b=3, bin=0, start for 1 cycle → done 8 cycles later; diff=0x00000002, bout=0, zero=0, ovf=0, lt=0.
- a=0, b=1 → diff=0xFFFFFFFF, bout=1, lt=1, ovf=0. Checks borrow rippling across all 8 nibbles.
- a=0x80000000, b=1 → diff=0x7FFFFFFF, ovf=1, lt=1, bout=0.
- a=b=0x1234ABCD, then a=7, b=7, bin=1 → first result zero=1. Second result diff=0xFFFFFFFF, bout=1.
- Start pulse held during RUN with different operands → ignored, and the original result is returned. Start asserted in the DONE cycle → second done exactly 9 cycles after the first.
- rst=1 during the 4th RUN cycle → next cycle busy=0, no done, all outputs 0. A new start afterwards completes normally.
